// File: rtl/axi_read_responder.sv
// axi_read_responder: AXI4 read-channel slave in front of a single-port synchronous SRAM.
//
// Accepted AR requests are queued in order. The issue engine walks each burst
// (FIXED / INCR / WRAP) one SRAM word per cycle. SRAM data comes back one cycle
// later and lands in a 2-entry R buffer whose head drives the R channel.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_axi_ar*         read address channel (arready = queue not full)
//   s_axi_r*          read data channel, full rready backpressure
//   OUT_MEM_ce/addr   SRAM read strobe and word address
//   IN_MEM_data       SRAM read data, valid the cycle after OUT_MEM_ce
//
// Optional feature: define AXIRSP_RANDSTALL_EN to let a 16-bit LFSR insert
// random issue gaps (ordering and data unchanged).
module axi_read_responder #(
  parameter int unsigned ID_LEN       = 2,
  parameter int unsigned ADDR_LEN     = 32,
  parameter int unsigned WIDTH        = 128,
  parameter int unsigned MEM_ADDR_LEN = 16,
  parameter int unsigned AR_DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_LEN-1:0]       s_axi_arid,
  input  logic [ADDR_LEN-1:0]     s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_LEN-1:0]       s_axi_rid,
  output logic [WIDTH-1:0]        s_axi_rdata,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    OUT_MEM_ce,
  output logic [MEM_ADDR_LEN-1:0] OUT_MEM_addr,
  input  logic [WIDTH-1:0]        IN_MEM_data
);

  localparam int unsigned OFFS = $clog2(WIDTH / 8);
  localparam int unsigned AQW  = $clog2(AR_DEPTH);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  // ---------------- AR request queue ----------------
  logic [ID_LEN-1:0]       aq_id    [AR_DEPTH];
  logic [MEM_ADDR_LEN-1:0] aq_addr  [AR_DEPTH];
  logic [7:0]              aq_len   [AR_DEPTH];
  logic [1:0]              aq_burst [AR_DEPTH];
  logic [AQW-1:0]          aq_wr_q, aq_rd_q;
  logic [AQW:0]            aq_cnt_q;
  logic                    aq_full, aq_empty, aq_push, aq_pop;
  logic [ADDR_LEN-1:0]     araddr_sh;
  logic                    unused_araddr;

  assign araddr_sh     = s_axi_araddr >> OFFS;
  assign unused_araddr = ^araddr_sh;
  assign aq_full       = (aq_cnt_q == (AQW+1)'(AR_DEPTH));
  assign aq_empty      = (aq_cnt_q == '0);
  assign s_axi_arready = !rst && !aq_full;
  assign aq_push       = s_axi_arvalid && s_axi_arready;

  always_ff @(posedge clk) begin
    if (aq_push) begin
      aq_id[aq_wr_q]    <= s_axi_arid;
      aq_addr[aq_wr_q]  <= araddr_sh[MEM_ADDR_LEN-1:0];
      aq_len[aq_wr_q]   <= s_axi_arlen;
      aq_burst[aq_wr_q] <= s_axi_arburst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aq_wr_q  <= '0;
      aq_rd_q  <= '0;
      aq_cnt_q <= '0;
    end else begin
      if (aq_push) aq_wr_q <= aq_wr_q + AQW'(1);
      if (aq_pop)  aq_rd_q <= aq_rd_q + AQW'(1);
      aq_cnt_q <= aq_cnt_q + (AQW+1)'(aq_push) - (AQW+1)'(aq_pop);
    end
  end

  // ---------------- R buffer (2 entries) ----------------
  logic [ID_LEN-1:0] r_id   [2];
  logic [WIDTH-1:0]  r_data [2];
  logic              r_last [2];
  logic              r_wr_q, r_rd_q;
  logic [1:0]        r_cnt_q;
  logic              r_valid, r_pop;
  logic              inflight_q, tag_last_q;
  logic [ID_LEN-1:0] tag_id_q;

  assign r_valid      = (r_cnt_q != 2'd0);
  assign r_pop        = r_valid && s_axi_rready;
  assign s_axi_rvalid = r_valid;
  assign s_axi_rid    = r_valid ? r_id[r_rd_q]   : '0;
  assign s_axi_rdata  = r_valid ? r_data[r_rd_q] : '0;
  assign s_axi_rlast  = r_valid && r_last[r_rd_q];

  always_ff @(posedge clk) begin
    if (inflight_q) begin
      r_id[r_wr_q]   <= tag_id_q;
      r_data[r_wr_q] <= IN_MEM_data;
      r_last[r_wr_q] <= tag_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_q  <= 1'b0;
      r_rd_q  <= 1'b0;
      r_cnt_q <= 2'd0;
    end else begin
      if (inflight_q) r_wr_q <= ~r_wr_q;
      if (r_pop)      r_rd_q <= ~r_rd_q;
      r_cnt_q <= r_cnt_q + 2'(inflight_q) - 2'(r_pop);
    end
  end

  // ---------------- Issue engine ----------------
  state_e                  state_q;
  logic [7:0]              beat_q, beat_cur, hd_len;
  logic [MEM_ADDR_LEN-1:0] cur_addr_q, iss_addr, next_addr, wrap_mask;
  logic [ID_LEN-1:0]       hd_id;
  logic [1:0]              hd_burst;
  logic [2:0]              credit_use;
  logic                    iss_last, wrap_ok, issue, stall;

`ifdef AXIRSP_RANDSTALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // Beat 0 is issued straight from the queue head so that an AR accepted in
  // cycle 0 reaches the SRAM in cycle 1; later beats use cur_addr_q.
  always_comb begin
    hd_id      = aq_id[aq_rd_q];
    hd_len     = aq_len[aq_rd_q];
    hd_burst   = aq_burst[aq_rd_q];
    iss_addr   = (state_q == StBurst) ? cur_addr_q : aq_addr[aq_rd_q];
    beat_cur   = (state_q == StBurst) ? beat_q : 8'd0;
    iss_last   = (beat_cur == hd_len);
    wrap_ok    = (hd_burst == 2'd2) &&
                 ((hd_len == 8'd1) || (hd_len == 8'd3) || (hd_len == 8'd7) || (hd_len == 8'd15));
    wrap_mask  = MEM_ADDR_LEN'(hd_len);
    if (hd_burst == 2'd0)  next_addr = iss_addr;
    else if (wrap_ok)      next_addr = (iss_addr & ~wrap_mask) |
                                       ((iss_addr + MEM_ADDR_LEN'(1)) & wrap_mask);
    else                   next_addr = iss_addr + MEM_ADDR_LEN'(1);
    // Buffered + in-flight beats, minus the one leaving this cycle, must stay below 2.
    credit_use = 3'(r_cnt_q) + 3'(inflight_q) - 3'(r_pop);
    issue      = !rst && !aq_empty && (credit_use < 3'd2) && !stall;
  end

  assign aq_pop       = issue && iss_last;
  assign OUT_MEM_ce   = issue;
  assign OUT_MEM_addr = issue ? iss_addr : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      beat_q     <= 8'd0;
      cur_addr_q <= '0;
      inflight_q <= 1'b0;
      tag_id_q   <= '0;
      tag_last_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        tag_id_q   <= hd_id;
        tag_last_q <= iss_last;
        if (iss_last) begin
          state_q <= StIdle;
          beat_q  <= 8'd0;
        end else begin
          state_q    <= StBurst;
          beat_q     <= beat_cur + 8'd1;
          cur_addr_q <= next_addr;
        end
      end
    end
  end

endmodule
